// File: rtl/pc_fetch_unit.sv
// IF-stage program counter with boot/run/halt sequencing, EX-stage redirect handling,
// wrong-path squash signals and a count of fetches that entered IF/ID.
module pc_fetch_unit #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter int unsigned          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_target_i,
    input  logic              halt_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] post_pc_o,
    output logic              valid_o,
    output logic              flush_ifid_o,
    output logic              flush_idex_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  fetch_cnt_o
);

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    state_e              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_valid;
    logic                r_halted;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_run;
    logic                w_halt_take;

    assign w_run       = (r_state == StRun);
    // A halt seen while ID is frozen is not acted on until the stall clears.
    assign w_halt_take = halt_i && !stall_i;

    assign flush_ifid_o = w_run && (redirect_i || w_halt_take);
    assign flush_idex_o = w_run && redirect_i;

    assign pc_o        = r_pc;
    assign post_pc_o   = r_pc + ADDR_W'(1);
    assign valid_o     = r_valid;
    assign halted_o    = r_halted;
    assign fetch_cnt_o = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StBoot;
            r_pc     <= RESET_PC;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                StBoot: begin
                    r_state <= StRun;
                    r_valid <= 1'b1;
                end
                StRun: begin
                    if (redirect_i) begin
                        r_pc <= redirect_target_i;
                    end else if (w_halt_take) begin
                        r_state  <= StHalt;
                        r_valid  <= 1'b0;
                        r_halted <= 1'b1;
                    end else if (!stall_i) begin
                        r_pc  <= r_pc + ADDR_W'(1);
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StHalt: begin
                    // Only reset leaves the halted state.
                    r_valid  <= 1'b0;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= StHalt;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic checked against a
// cycle-level reference model; a 4-bit instance shares the stimulus to exercise wrap-around.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic        halt_i = 1'b0;
    logic [31:0] target = '0;

    logic [31:0] pc, post_pc, fetch_cnt;
    logic        valid, flush_ifid, flush_idex, halted;
    logic [3:0]  s_pc, s_post_pc, s_fetch_cnt;
    logic        s_valid, s_flush_ifid, s_flush_idex, s_halted;

    int checks = 0;
    int failures = 0;

    // Reference model: boot flag, halted flag, pc, fetch count.
    bit          m_boot;
    bit          m_halt;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_target_i(target), .halt_i(halt_i), .pc_o(pc), .post_pc_o(post_pc),
        .valid_o(valid), .flush_ifid_o(flush_ifid), .flush_idex_o(flush_idex),
        .halted_o(halted), .fetch_cnt_o(fetch_cnt)
    );

    pc_fetch_unit #(.ADDR_W(4), .RESET_PC(4'h0), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_target_i(target[3:0]), .halt_i(halt_i), .pc_o(s_pc),
        .post_pc_o(s_post_pc), .valid_o(s_valid), .flush_ifid_o(s_flush_ifid),
        .flush_idex_o(s_flush_idex), .halted_o(s_halted), .fetch_cnt_o(s_fetch_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic reset_model();
        m_boot = 1'b1;
        m_halt = 1'b0;
        m_pc   = 32'h0;
        m_cnt  = 32'h0;
    endtask

    task automatic set_in(input bit st, input bit rd, input logic [31:0] tg, input bit hl);
        stall_i    = st;
        redirect_i = rd;
        target     = tg;
        halt_i     = hl;
        #1;
    endtask

    // One clock edge; model follows the fetch rules using the inputs held across the edge.
    task automatic tick();
        @(posedge clk);
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (!m_halt) begin
            if (redirect_i) m_pc = target;
            else if (halt_i && !stall_i) m_halt = 1'b1;
            else if (!stall_i) begin
                m_pc  = m_pc + 1;
                m_cnt = m_cnt + 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 32'h0, 0);
        rst_n = 1'b0;
        #3;
        reset_model();
        rst_n = 1'b1;
    endtask

    task automatic run_to(input logic [31:0] t);
        for (int i = 0; i < 64 && m_pc != t; i++) begin
            set_in(0, 0, 32'h0, 0);
            tick();
        end
        checks++; if (pc !== t) begin failures++; $display("FAIL run_to_pc got=%0h exp=%0h", pc, t); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1, 1, 32'h55, 1);
        repeat (3) @(posedge clk);
        #2;
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%0h exp=0", pc); end
        checks++; if (post_pc !== 32'h1) begin failures++; $display("FAIL rst_post_pc got=%0h exp=1", post_pc); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", valid); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%0b exp=0", halted); end
        checks++; if (fetch_cnt !== 32'h0) begin failures++; $display("FAIL rst_cnt got=%0h exp=0", fetch_cnt); end
        checks++; if ({flush_ifid, flush_idex} !== 2'b00) begin failures++; $display("FAIL rst_flush got=%0b exp=00", {flush_ifid, flush_idex}); end
    endtask

    task automatic test_boot();
        do_reset();
        set_in(1, 1, 32'h77, 0);  // ignored during boot
        checks++; if ({pc, valid} !== {32'h0, 1'b0}) begin failures++; $display("FAIL boot_c1 got pc=%0h v=%0b exp pc=0 v=0", pc, valid); end
        checks++; if ({flush_ifid, flush_idex} !== 2'b00) begin failures++; $display("FAIL boot_flush got=%0b exp=00", {flush_ifid, flush_idex}); end
        tick();
        set_in(0, 0, 32'h0, 0);
        checks++; if ({pc, valid} !== {32'h0, 1'b1}) begin failures++; $display("FAIL boot_c2 got pc=%0h v=%0b exp pc=0 v=1", pc, valid); end
        checks++; if (fetch_cnt !== 32'h0) begin failures++; $display("FAIL boot_c2_cnt got=%0h exp=0", fetch_cnt); end
        tick();
        checks++; if ({pc, post_pc} !== {32'h1, 32'h2}) begin failures++; $display("FAIL boot_c3 got pc=%0h post=%0h exp 1/2", pc, post_pc); end
        checks++; if (fetch_cnt !== 32'h1) begin failures++; $display("FAIL boot_c3_cnt got=%0h exp=1", fetch_cnt); end
    endtask

    task automatic test_redirect();
        do_reset();
        run_to(32'h5);
        set_in(0, 1, 32'h20, 0);
        checks++; if ({flush_ifid, flush_idex} !== 2'b11) begin failures++; $display("FAIL redir_flush got=%0b exp=11", {flush_ifid, flush_idex}); end
        checks++; if (fetch_cnt !== 32'h5) begin failures++; $display("FAIL redir_cnt_before got=%0h exp=5", fetch_cnt); end
        tick();
        set_in(0, 0, 32'h0, 0);
        checks++; if ({pc, post_pc} !== {32'h20, 32'h21}) begin failures++; $display("FAIL redir_pc got pc=%0h post=%0h exp 20/21", pc, post_pc); end
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL redir_valid got=%0b exp=1", valid); end
        checks++; if (fetch_cnt !== 32'h5) begin failures++; $display("FAIL redir_cnt_after got=%0h exp=5", fetch_cnt); end
        checks++; if ({flush_ifid, flush_idex} !== 2'b00) begin failures++; $display("FAIL redir_flush_clear got=%0b exp=00", {flush_ifid, flush_idex}); end
    endtask

    task automatic test_priority();
        do_reset();
        run_to(32'h8);
        set_in(1, 1, 32'h3, 1);
        checks++; if ({flush_ifid, flush_idex} !== 2'b11) begin failures++; $display("FAIL prio_flush got=%0b exp=11", {flush_ifid, flush_idex}); end
        tick();
        set_in(0, 0, 32'h0, 0);
        checks++; if (pc !== 32'h3) begin failures++; $display("FAIL prio_pc got=%0h exp=3", pc); end
        checks++; if ({halted, valid} !== 2'b01) begin failures++; $display("FAIL prio_state got h/v=%0b exp=01", {halted, valid}); end
    endtask

    task automatic test_stall();
        do_reset();
        run_to(32'hA);
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 32'h0, (i == 1));  // halt under stall must be ignored
            checks++; if ({pc, valid} !== {32'hA, 1'b1}) begin failures++; $display("FAIL stall_pc got pc=%0h v=%0b exp A/1", pc, valid); end
            checks++; if ({flush_ifid, flush_idex} !== 2'b00) begin failures++; $display("FAIL stall_flush got=%0b exp=00", {flush_ifid, flush_idex}); end
            checks++; if (fetch_cnt !== 32'hA) begin failures++; $display("FAIL stall_cnt got=%0h exp=A", fetch_cnt); end
            tick();
        end
        set_in(0, 0, 32'h0, 0);
        checks++; if ({pc, halted} !== {32'hA, 1'b0}) begin failures++; $display("FAIL stall_last got pc=%0h h=%0b exp A/0", pc, halted); end
        tick();
        checks++; if (pc !== 32'hB) begin failures++; $display("FAIL stall_release got=%0h exp=B", pc); end
    endtask

    task automatic test_halt();
        do_reset();
        run_to(32'h7);
        set_in(0, 0, 32'h0, 1);
        checks++; if ({flush_ifid, flush_idex} !== 2'b10) begin failures++; $display("FAIL halt_flush got=%0b exp=10", {flush_ifid, flush_idex}); end
        tick();
        set_in(0, 1, 32'h40, 0);
        checks++; if ({halted, valid, pc} !== {1'b1, 1'b0, 32'h7}) begin failures++; $display("FAIL halt_state got h=%0b v=%0b pc=%0h exp 1/0/7", halted, valid, pc); end
        checks++; if ({flush_ifid, flush_idex} !== 2'b00) begin failures++; $display("FAIL halt_redir_flush got=%0b exp=00", {flush_ifid, flush_idex}); end
        checks++; if (post_pc !== 32'h8) begin failures++; $display("FAIL halt_post_pc got=%0h exp=8", post_pc); end
        tick();
        checks++; if ({pc, halted} !== {32'h7, 1'b1}) begin failures++; $display("FAIL halt_redir_ignored got pc=%0h h=%0b exp 7/1", pc, halted); end
        rst_n = 1'b0;
        #1;
        checks++; if ({pc, halted, valid} !== {32'h0, 1'b0, 1'b0}) begin failures++; $display("FAIL halt_async_rst got pc=%0h h=%0b v=%0b exp 0/0/0", pc, halted, valid); end
        reset_model();
        set_in(0, 0, 32'h0, 0);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset();
        run_to(32'h2);
        set_in(0, 1, 32'hF, 0);
        tick();
        set_in(0, 0, 32'h0, 0);
        checks++; if ({s_pc, s_post_pc} !== {4'hF, 4'h0}) begin failures++; $display("FAIL wrap4_pc got pc=%0h post=%0h exp F/0", s_pc, s_post_pc); end
        tick();
        checks++; if (s_pc !== 4'h0) begin failures++; $display("FAIL wrap4_next got=%0h exp=0", s_pc); end
        checks++; if (pc !== 32'h10) begin failures++; $display("FAIL wrap32_ref got=%0h exp=10", pc); end
        set_in(0, 1, 32'hFFFF_FFFF, 0);
        tick();
        set_in(0, 0, 32'h0, 0);
        checks++; if (post_pc !== 32'h0) begin failures++; $display("FAIL wrap32_post got=%0h exp=0", post_pc); end
        tick();
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap32_next got=%0h exp=0", pc); end
    endtask

    task automatic test_random();
        logic        e_run;
        logic        e_fi, e_fx;
        logic [31:0] tg;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (m_halt && ($urandom % 6 == 0)) do_reset();
            tg = ($urandom % 4 == 0) ? m_pc : $urandom;
            set_in(($urandom % 4) == 0, ($urandom % 7) == 0, tg, ($urandom % 40) == 0);
            e_run = !m_boot && !m_halt;
            e_fi  = e_run && (redirect_i || (halt_i && !stall_i));
            e_fx  = e_run && redirect_i;
            checks++; if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc cyc=%0d got=%0h exp=%0h", i, pc, m_pc); end
            checks++; if (post_pc !== m_pc + 32'h1) begin failures++; $display("FAIL rnd_post cyc=%0d got=%0h exp=%0h", i, post_pc, m_pc + 32'h1); end
            checks++; if (valid !== e_run) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", i, valid, e_run); end
            checks++; if (halted !== m_halt) begin failures++; $display("FAIL rnd_halted cyc=%0d got=%0b exp=%0b", i, halted, m_halt); end
            checks++; if ({flush_ifid, flush_idex} !== {e_fi, e_fx}) begin failures++; $display("FAIL rnd_flush cyc=%0d got=%0b exp=%0b", i, {flush_ifid, flush_idex}, {e_fi, e_fx}); end
            checks++; if (fetch_cnt !== m_cnt) begin failures++; $display("FAIL rnd_cnt cyc=%0d got=%0h exp=%0h", i, fetch_cnt, m_cnt); end
            checks++; if ({s_pc, s_post_pc} !== {m_pc[3:0], 4'(m_pc[3:0] + 4'h1)}) begin failures++; $display("FAIL rnd_small_pc cyc=%0d got=%0h/%0h exp=%0h", i, s_pc, s_post_pc, m_pc[3:0]); end
            checks++; if ({s_valid, s_halted, s_flush_ifid, s_flush_idex} !== {e_run, m_halt, e_fi, e_fx}) begin failures++; $display("FAIL rnd_small_ctl cyc=%0d got=%0b exp=%0b", i, {s_valid, s_halted, s_flush_ifid, s_flush_idex}, {e_run, m_halt, e_fi, e_fx}); end
            checks++; if (s_fetch_cnt !== m_cnt[3:0]) begin failures++; $display("FAIL rnd_small_cnt cyc=%0d got=%0h exp=%0h", i, s_fetch_cnt, m_cnt[3:0]); end
            tick();
        end
    endtask

    initial begin
        reset_model();
        test_reset();
        test_boot();
        test_redirect();
        test_priority();
        test_stall();
        test_halt();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
IF-stage program-counter and redirect controller; the consuming end of the EX-stage branch-target path. The EX stage computes the target as PostPc + offset - 1, and this block returns PostPc (pc + 1, word addressing) to that stage. It accepts the resolved target plus a taken flag, reloads the PC and squashes wrong-path instructions in IF/ID and ID/EX. It also handles hazard stalls, halt and boot sequencing, and counts retired fetches.

Parameters:
ADDR_W, 32, PC / target width (word address)
RESET_PC, 0, PC value loaded on reset
CNT_W, 32, width of fetch counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
stall_i  input  1  hazard-unit freeze of PC and IF/ID
redirect_i  input  1  branch/jump taken, resolved in EX this cycle
redirect_target_i  input  ADDR_W  target address from EX adder
halt_i  input  1  halt opcode decoded in ID this cycle
pc_o  output  ADDR_W  instruction-memory address (registered)
post_pc_o  output  ADDR_W  pc_o + 1, forwarded down the pipe (combinational from pc_o)
valid_o  output  1  instruction at pc_o is a real fetch
flush_ifid_o  output  1  squash IF/ID this edge (combinational)
flush_idex_o  output  1  squash ID/EX this edge (combinational)
halted_o  output  1  core halted
fetch_cnt_o  output  CNT_W  count of fetches that entered IF/ID unsquashed

Behaviour:
- Reset (async, rst_n=0): pc_o=RESET_PC, post_pc_o=RESET_PC+1, valid_o=0, halted_o=0, fetch_cnt_o=0, state=S_BOOT. Flush outputs are 0 while rst_n=0.
- FSM states: S_BOOT, S_RUN, S_HALT.
- S_BOOT: lasts exactly one cycle after rst_n deasserts. pc holds RESET_PC. valid_o=0. Next state is S_RUN, in which valid_o=1 with pc_o=RESET_PC. stall_i and redirect_i are ignored in S_BOOT.
- S_RUN priority, highest first: redirect_i, halt_i, stall_i, normal.
  - redirect_i=1: flush_ifid_o=flush_idex_o=1 in the same cycle. Next edge pc <= redirect_target_i. Redirect overrides stall_i and halt_i; the halt is wrong-path. The counter does not increment.
  - halt_i=1 (no redirect, stall_i=0): next state S_HALT. pc holds. flush_ifid_o=1 in that cycle; the instruction behind the halt is squashed. flush_idex_o=0.
  - halt_i=1 with stall_i=1: ignored until stall_i drops, because ID is frozen.
  - stall_i=1: pc holds and valid_o stays 1. No flushes. The counter holds.
  - Normal: pc <= pc + 1, modulo 2^ADDR_W; all-ones wraps to 0. fetch_cnt_o increments by 1 and wraps at 2^CNT_W.
- S_HALT: valid_o=0, halted_o=1, pc frozen. All inputs are ignored, including redirect_i. Only reset exits.
- post_pc_o = pc_o + 1 truncated to ADDR_W at all times, including in S_HALT.
- Latency: redirect asserted in cycle N gives pc_o=target in cycle N+1 with valid_o=1. The penalty is 2 squashed slots.
- Targets are unconstrained; a target equal to the current pc is legal and refetches that address.
- Reset asserted mid-operation, in any state, returns all state to the reset values immediately. No pending redirect survives reset.

Test Plan:
- Boot: release rst_n -> cycle 1 pc_o=0, valid_o=0. Cycle 2 pc_o=0, valid_o=1. Cycle 3 pc_o=1, post_pc_o=2. fetch_cnt_o increments from cycle 2.
- Redirect: at pc_o=5, redirect_i=1, target=0x20 -> flush_ifid_o=flush_idex_o=1 that cycle. Next cycle pc_o=0x20, post_pc_o=0x21. fetch_cnt_o unchanged across the redirect cycle.
- Redirect vs stall vs halt: at pc_o=8, assert stall_i=1, halt_i=1, redirect_i=1, target=3 -> pc_o=3 next cycle, halted_o=0, both flushes=1.
- Stall: at pc_o=10, stall_i=1 for 3 cycles -> pc_o=10 and valid_o=1 throughout, counter frozen. On release pc_o=11.
- Halt: at pc_o=7, halt_i=1 with stall_i=0 -> flush_ifid_o=1. Next cycle halted_o=1, valid_o=0, pc_o=7. A later redirect_i=1 has no effect. rst_n low returns pc_o=0, halted_o=0 asynchronously.
- Wrap: ADDR_W=4, redirect to 0xF -> next fetch pc_o=0xF, post_pc_o=0x0, following cycle pc_o=0x0.
